// File: rtl/qdec_pkg.sv
// rtl/qdec_pkg.sv - shared types and constants for the qdec bitstream fetch front-end
package qdec_pkg;

  // One byte FIFO entry: payload byte plus end-of-NAL marker
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } t_bs_entry_s;

  // Emulation-prevention byte value and the zero run that must precede it
  localparam logic [7:0] QDEC_EPB_BYTE     = 8'h03;
  localparam int         QDEC_EPB_ZERO_RUN = 2;

  // Zero-run counter increment, saturating at the EPB trigger length
  function automatic logic [1:0] qdec_zr_inc(input logic [1:0] zr);
    if (zr >= 2'(QDEC_EPB_ZERO_RUN)) begin
      return 2'(QDEC_EPB_ZERO_RUN);
    end
    return zr + 2'd1;
  endfunction

endpackage

// File: rtl/qdec_bs_epb_filter.sv
// rtl/qdec_bs_epb_filter.sv - per-word EPB removal and byte compaction (EPB removal enabled by QDEC_BS_EPB_EN)
module qdec_bs_epb_filter
  import qdec_pkg::*;
#(
  parameter  int IN_BYTES = 4,
  localparam int CNT_W    = $clog2(IN_BYTES + 1)
) (
`ifdef QDEC_BS_EPB_EN
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          accept_i,
  input  logic                          flush_i,
  output logic [CNT_W-1:0]              drop_cnt_o,
`endif
  input  logic [8*IN_BYTES-1:0]         in_data_i,
  input  logic [IN_BYTES-1:0]           in_keep_i,
  input  logic                          in_last_i,
  output t_bs_entry_s [IN_BYTES-1:0]    entries_o,
  output logic [CNT_W-1:0]              count_o
);

  // keep mask extended by one cleared bit so the final kept byte is found without range checks
  logic [IN_BYTES:0] keep_ext;
  assign keep_ext = {1'b0, in_keep_i};

`ifdef QDEC_BS_EPB_EN
  logic [1:0] zero_run_q;
  logic [1:0] zero_run_d;

  // Walk kept bytes in stream order, drop EPBs and pack survivors from slot 0 upward
  always_comb begin
    logic [7:0] byte_v;
    logic       tail;
    logic       drop;
    logic [1:0] zr;
    int         cnt;
    int         drops;
    entries_o = '0;
    zr        = zero_run_q;
    cnt       = 0;
    drops     = 0;
    byte_v    = '0;
    tail      = 1'b0;
    drop      = 1'b0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (in_keep_i[i]) begin
        byte_v = in_data_i[8*i +: 8];
        tail   = in_last_i && !keep_ext[i+1];
        drop   = 1'b0;
        // The closing byte of a NAL is always delivered, even if it looks like an EPB
        if (byte_v == QDEC_EPB_BYTE && zr == 2'(QDEC_EPB_ZERO_RUN) && !tail) begin
          drop  = 1'b1;
          zr    = 2'd0;
          drops = drops + 1;
        end else if (byte_v == 8'h00) begin
          zr = qdec_zr_inc(zr);
        end else begin
          zr = 2'd0;
        end
        if (!drop) begin
          for (int j = 0; j < IN_BYTES; j++) begin
            if (j == cnt) begin
              entries_o[j] = '{last: tail, data: byte_v};
            end
          end
          cnt = cnt + 1;
        end
      end
    end
    // A new NAL never inherits a zero run from the previous one
    zero_run_d = in_last_i ? 2'd0 : zr;
    count_o    = CNT_W'(cnt);
    drop_cnt_o = CNT_W'(drops);
  end

  // Zero-run state advances only on accepted words; flush returns it to idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_run_q <= 2'd0;
    end else if (flush_i) begin
      zero_run_q <= 2'd0;
    end else if (accept_i) begin
      zero_run_q <= zero_run_d;
    end
  end
`else
  // Pass-through: every kept byte survives, only the NAL tail marker is added
  always_comb begin
    int cnt;
    entries_o = '0;
    cnt       = 0;
    for (int i = 0; i < IN_BYTES; i++) begin
      if (in_keep_i[i]) begin
        entries_o[i] = '{last: in_last_i && !keep_ext[i+1], data: in_data_i[8*i +: 8]};
        cnt          = cnt + 1;
      end
    end
    count_o = CNT_W'(cnt);
  end
`endif

endmodule

// File: rtl/qdec_bs_fetch.sv
// rtl/qdec_bs_fetch.sv - bitstream fetch front-end: word input, byte FIFO, byte output (EPB removal with QDEC_BS_EPB_EN)
module qdec_bs_fetch
  import qdec_pkg::*;
#(
  parameter int IN_BYTES   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [8*IN_BYTES-1:0]             in_data,
  input  logic [IN_BYTES-1:0]               in_keep,
  input  logic                              in_last,
  input  logic                              in_vld,
  output logic                              in_rdy,
  input  logic                              flush,
  output logic [7:0]                        bitstreamFetch,
  output logic                              bitstreamFetch_last,
  output logic                              bitstreamFetch_vld,
  input  logic                              bitstreamFetch_rdy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic [15:0]                       epb_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(IN_BYTES + 1);

  t_bs_entry_s                 mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]            level_q,  level_d;
  logic                        ready_en_q;
  logic [15:0]                 epb_cnt_q, epb_cnt_d;

  t_bs_entry_s [IN_BYTES-1:0]  push_ent;
  logic [CNT_W-1:0]            push_cnt;
  logic [LVL_W-1:0]            space;
  logic                        accept;
  logic                        pop;
  t_bs_entry_s                 head;

  // Worst-case space check from the registered level; flush blocks input for its cycle
  assign space  = LVL_W'(FIFO_DEPTH) - level_q;
  assign in_rdy = ready_en_q && !flush && (space >= LVL_W'(IN_BYTES));
  assign accept = in_vld && in_rdy;

  assign bitstreamFetch_vld = (level_q != '0);
  assign pop                = bitstreamFetch_vld && bitstreamFetch_rdy && !flush;
  assign head               = mem_q[rd_ptr_q];

  // Show-ahead head entry; an empty FIFO presents zeros rather than stale storage
  assign bitstreamFetch      = bitstreamFetch_vld ? head.data : 8'h00;
  assign bitstreamFetch_last = bitstreamFetch_vld ? head.last : 1'b0;
  assign fifo_level          = level_q;

`ifdef QDEC_BS_EPB_EN
  logic [CNT_W-1:0] drop_cnt;
  logic [16:0]      epb_sum;

  qdec_bs_epb_filter #(
    .IN_BYTES   (IN_BYTES)
  ) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept_i   (accept),
    .flush_i    (flush),
    .drop_cnt_o (drop_cnt),
    .in_data_i  (in_data),
    .in_keep_i  (in_keep),
    .in_last_i  (in_last),
    .entries_o  (push_ent),
    .count_o    (push_cnt)
  );

  // Removed-EPB counter accumulates per accepted word and pins at all-ones
  always_comb begin
    epb_sum   = {1'b0, epb_cnt_q} + 17'(drop_cnt);
    epb_cnt_d = epb_cnt_q;
    if (flush) begin
      epb_cnt_d = '0;
    end else if (accept) begin
      epb_cnt_d = epb_sum[16] ? 16'hFFFF : epb_sum[15:0];
    end
  end
  assign epb_cnt = epb_cnt_q;
`else
  qdec_bs_epb_filter #(
    .IN_BYTES   (IN_BYTES)
  ) u_filter (
    .in_data_i  (in_data),
    .in_keep_i  (in_keep),
    .in_last_i  (in_last),
    .entries_o  (push_ent),
    .count_o    (push_cnt)
  );

  assign epb_cnt_d = '0;
  assign epb_cnt   = 16'h0000;
`endif

  // Pointer and level next-state; flush wins over any push or pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + (accept ? LVL_W'(push_cnt) : LVL_W'(0)) - (pop ? LVL_W'(1) : LVL_W'(0));
    end
  end

  // Control registers; ready_en holds input off until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      epb_cnt_q  <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      epb_cnt_q  <= epb_cnt_d;
      ready_en_q <= 1'b1;
    end
  end

  // Byte storage: surviving entries land at consecutive slots from the write pointer
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < IN_BYTES; j++) begin
        if (CNT_W'(j) < push_cnt) begin
          mem_q[wr_ptr_q + PTR_W'(j)] <= push_ent[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_qdec_bs_fetch.sv
// tb/tb_qdec_bs_fetch.sv - self-checking bench for qdec_bs_fetch (follows QDEC_BS_EPB_EN)
module tb_qdec_bs_fetch;

  localparam int IN_BYTES   = 4;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [8*IN_BYTES-1:0]   in_data = '0;
  logic [IN_BYTES-1:0]     in_keep = '0;
  logic                    in_last = 1'b0;
  logic                    in_vld = 1'b0;
  logic                    in_rdy;
  logic                    flush = 1'b0;
  logic [7:0]              bitstreamFetch;
  logic                    bitstreamFetch_last;
  logic                    bitstreamFetch_vld;
  logic                    bitstreamFetch_rdy = 1'b0;
  logic [LVL_W-1:0]        fifo_level;
  logic [15:0]             epb_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: expected FIFO contents as {last, data}, filter zero run, EPB count
  logic [8:0] mq[$];
  int         m_zr = 0;
  int         m_epb = 0;
  bit         m_ready_en = 0;

  qdec_bs_fetch #(
    .IN_BYTES            (IN_BYTES),
    .FIFO_DEPTH          (FIFO_DEPTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_data             (in_data),
    .in_keep             (in_keep),
    .in_last             (in_last),
    .in_vld              (in_vld),
    .in_rdy              (in_rdy),
    .flush               (flush),
    .bitstreamFetch      (bitstreamFetch),
    .bitstreamFetch_last (bitstreamFetch_last),
    .bitstreamFetch_vld  (bitstreamFetch_vld),
    .bitstreamFetch_rdy  (bitstreamFetch_rdy),
    .fifo_level          (fifo_level),
    .epb_cnt             (epb_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the stream rules to the word currently on the input pins
  task automatic model_word();
    int         n;
    logic [7:0] b;
    bit         tail;
    bit         drop;
    n = 0;
    while (n < IN_BYTES && in_keep[n]) n++;
    for (int i = 0; i < n; i++) begin
      b    = in_data[8*i +: 8];
      tail = in_last && (i == n - 1);
      drop = 0;
`ifdef QDEC_BS_EPB_EN
      if (b == 8'h03 && m_zr == 2 && !tail) begin
        drop = 1;
        m_zr = 0;
        if (m_epb < 65535) m_epb++;
      end else if (b == 8'h00) begin
        m_zr = (m_zr < 2) ? m_zr + 1 : 2;
      end else begin
        m_zr = 0;
      end
`endif
      if (!drop) mq.push_back({tail, b});
    end
    if (in_last) m_zr = 0;
  endtask

  task automatic check_all();
    bit exp_rdy;
    exp_rdy = m_ready_en && !flush && (FIFO_DEPTH - mq.size() >= IN_BYTES);
    chk("out_vld", 32'(bitstreamFetch_vld), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_data", 32'(bitstreamFetch), 32'(mq[0][7:0]));
      chk("out_last", 32'(bitstreamFetch_last), 32'(mq[0][8]));
    end
    chk("level", 32'(fifo_level), 32'(mq.size()));
    chk("epb_cnt", 32'(epb_cnt), 32'(m_epb));
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
  endtask

  // One clock: predict transfers from current inputs, advance model, compare
  task automatic step();
    bit acc;
    bit pp;
    acc = in_vld && m_ready_en && !flush && (FIFO_DEPTH - mq.size() >= IN_BYTES);
    pp  = !flush && (mq.size() != 0) && bitstreamFetch_rdy;
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_zr  = 0;
      m_epb = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) model_word();
    end
    m_ready_en = 1;
    #1;
    check_all();
  endtask

  task automatic drive_word(input logic [31:0] d, input int n, input bit last);
    in_data = d;
    in_keep = IN_BYTES'((1 << n) - 1);
    in_last = last;
    in_vld  = 1'b1;
  endtask

  task automatic drain();
    in_vld             = 1'b0;
    bitstreamFetch_rdy = 1'b1;
    for (int k = 0; k < 100 && mq.size() != 0; k++) step();
    chk("drain_empty", 32'(mq.size()), 32'd0);
  endtask

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(0, 3))
      0, 1:    return 8'h00;
      2:       return 8'h03;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic rnd_word();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = rnd_byte();
    drive_word(d, $urandom_range(1, IN_BYTES), $urandom_range(0, 7) == 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_vld", 32'(bitstreamFetch_vld), 32'd0);
    chk("rst_data", 32'(bitstreamFetch), 32'd0);
    chk("rst_last", 32'(bitstreamFetch_last), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_epb", 32'(epb_cnt), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("rel_in_rdy0", 32'(in_rdy), 32'd0);
    step();
    chk("rel_in_rdy1", 32'(in_rdy), 32'd1);

    // EPB at the top of one word, followed by a plain word
    bitstreamFetch_rdy = 1'b1;
    drive_word(32'h0300_0000, 4, 0);
    step();
`ifdef QDEC_BS_EPB_EN
    chk("epb_word_cnt", 32'(epb_cnt), 32'd1);
`else
    chk("epb_word_cnt", 32'(epb_cnt), 32'd0);
`endif
    drive_word(32'h0000_0011, 4, 0);
    step();
    drain();

    // EPB split across two words
    drive_word(32'h0000_0000, 2, 0);
    step();
    drive_word(32'h0000_4103, 2, 0);
    step();
    drain();

    // NAL tail 00 00 03 is kept, next NAL starting with 03 is not an EPB
    drive_word(32'h0003_0000, 3, 1);
    step();
    drive_word(32'h0000_0003, 1, 0);
    step();
    drain();

    // Output stalled with continuous input
    bitstreamFetch_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rnd_word();
      step();
    end
    chk("bp_level_high", 32'(fifo_level >= LVL_W'(FIFO_DEPTH - 3)), 32'd1);
    chk("bp_in_rdy", 32'(in_rdy), 32'd0);
    drain();

    // Flush with level 9 and a word on the input
    bitstreamFetch_rdy = 1'b0;
    drive_word(32'h4433_2211, 4, 0);
    step();
    step();
    drive_word(32'h0000_0055, 1, 0);
    step();
    in_vld = 1'b0;
    chk("pre_flush_level", 32'(fifo_level), 32'd9);
    flush = 1'b1;
    drive_word(32'hAAAA_AAAA, 4, 0);
    #1 chk("flush_in_rdy", 32'(in_rdy), 32'd0);
    step();
    flush = 1'b0;
    in_vld = 1'b0;
    chk("flush_level", 32'(fifo_level), 32'd0);
    chk("flush_vld", 32'(bitstreamFetch_vld), 32'd0);
    chk("flush_epb", 32'(epb_cnt), 32'd0);
    bitstreamFetch_rdy = 1'b1;
    step();
    step();

    // Randomised traffic with occasional flushes
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) != 0) rnd_word();
      else in_vld = 1'b0;
      bitstreamFetch_rdy = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0;
    drain();

    // Reset pulse mid-stream
    bitstreamFetch_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rnd_word();
      step();
    end
    #2 rst_n = 1'b0;
    in_vld = 1'b0;
    #1;
    mq.delete();
    m_zr = 0;
    m_epb = 0;
    m_ready_en = 0;
    chk("mid_rst_vld", 32'(bitstreamFetch_vld), 32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_data", 32'(bitstreamFetch), 32'd0);
    chk("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("mid_rel_in_rdy0", 32'(in_rdy), 32'd0);
    step();
    chk("mid_rel_in_rdy1", 32'(in_rdy), 32'd1);
    drive_word(32'h0302_0100, 4, 1);
    step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
